// File: rtl/rv32i_dmem_responder.sv
// rv32i_dmem_responder
//   Slave end of the core's data port. This block provides:
//   - a byte-maskable word RAM with a one-cycle registered read;
//   - a small MMIO window holding a 64-bit machine timer, a timer compare
//     with a level interrupt, and a 32-bit GPIO output register.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   addr       byte address from the core (daddr)
//   wdata      lane-aligned store data (core dout)
//   wr_mask    byte-lane enables {b3,b2,b1,b0}
//   wr_en      store strobe, one cycle per store
//   rdata      registered read data (core din), one cycle after addr
//   gpio_out   GPIO output register
//   timer_irq  registered level, high while mtime >= mtimecmp
//
// Address map
//   addr[31]=0 : RAM. The word index is addr[log2(DEPTH)+1:2]; higher bits alias.
//   addr[31]=1 : MMIO. The word offset is addr[7:2]. Registers by byte offset:
//                0x00 mtime_lo, 0x04 mtime_hi, 0x08 mtimecmp_lo,
//                0x0C mtimecmp_hi, 0x10 gpio_out, 0x14 status (bit0 = irq).
//                All other offsets read 0 and ignore writes.

module rv32i_dmem_responder #(
    parameter int DEPTH     = 1024,
    parameter int TIMER_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wr_mask,
    input  logic        wr_en,
    output logic [31:0] rdata,
    output logic [31:0] gpio_out,
    output logic        timer_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

    localparam logic [5:0] OFF_MTIME_LO = 6'd0;
    localparam logic [5:0] OFF_MTIME_HI = 6'd1;
    localparam logic [5:0] OFF_CMP_LO   = 6'd2;
    localparam logic [5:0] OFF_CMP_HI   = 6'd3;
    localparam logic [5:0] OFF_GPIO     = 6'd4;
    localparam logic [5:0] OFF_STATUS   = 6'd5;

    // Replace each byte lane whose mask bit is set; keep the others.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    // Address decode
    logic          mmio_sel;
    logic [AW-1:0] word_idx;
    logic [5:0]    mmio_off;
    logic          unused_addr_bits;

    assign mmio_sel = addr[31];
    assign word_idx = addr[AW+1:2];
    assign mmio_off = addr[7:2];
    // Not every address bit is decoded; the ignored bits alias.
    assign unused_addr_bits = ^{addr[30:8], addr[1:0]};

    logic wr_ram, wr_mmio;
    logic wr_tlo, wr_thi, wr_clo, wr_chi, wr_gpio;

    // A store that coincides with reset is dropped, RAM included.
    assign wr_ram  = wr_en & ~mmio_sel & rst_n;
    assign wr_mmio = wr_en & mmio_sel;
    assign wr_tlo  = wr_mmio & (mmio_off == OFF_MTIME_LO);
    assign wr_thi  = wr_mmio & (mmio_off == OFF_MTIME_HI);
    assign wr_clo  = wr_mmio & (mmio_off == OFF_CMP_LO);
    assign wr_chi  = wr_mmio & (mmio_off == OFF_CMP_HI);
    assign wr_gpio = wr_mmio & (mmio_off == OFF_GPIO);

    // State
    logic [31:0]   mem [DEPTH];
    logic [31:0]   mtime_lo, mtime_hi;
    logic [31:0]   cmp_lo, cmp_hi;
    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PRESC_MAX);

    // Next mtime. A write to one half takes priority over the tick for that
    // half. The carry between halves is suppressed whenever either half is
    // being written.
    logic [31:0] mtime_lo_nx, mtime_hi_nx, lo_inc;
    logic        lo_carry;

    always_comb begin
        {lo_carry, lo_inc} = {1'b0, mtime_lo} + 33'(tick);
        mtime_lo_nx = lo_inc;
        mtime_hi_nx = mtime_hi + 32'(lo_carry);
        if (wr_tlo) begin
            mtime_lo_nx = merge_lanes(mtime_lo, wdata, wr_mask);
            mtime_hi_nx = mtime_hi;
        end
        if (wr_thi) begin
            mtime_hi_nx = merge_lanes(mtime_hi, wdata, wr_mask);
        end
    end

    // Read mux. The mux uses pre-edge register values, so a read of a
    // location being written in the same cycle returns the old contents.
    logic [31:0] mmio_rd, rd_p0;

    always_comb begin
        mmio_rd = '0;
        case (mmio_off)
            OFF_MTIME_LO: mmio_rd = mtime_lo;
            OFF_MTIME_HI: mmio_rd = mtime_hi;
            OFF_CMP_LO:   mmio_rd = cmp_lo;
            OFF_CMP_HI:   mmio_rd = cmp_hi;
            OFF_GPIO:     mmio_rd = gpio_out;
            OFF_STATUS:   mmio_rd = {31'b0, timer_irq};
            default:      mmio_rd = '0;
        endcase
    end

    assign rd_p0 = mmio_sel ? mmio_rd : mem[word_idx];

    // ---- stage boundary: decoded read data -> rdata register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata     <= '0;
            gpio_out  <= '0;
            timer_irq <= 1'b0;
            mtime_lo  <= '0;
            mtime_hi  <= '0;
            cmp_lo    <= '1;
            cmp_hi    <= '1;
            presc     <= '0;
        end else begin
            rdata    <= rd_p0;
            presc    <= tick ? '0 : presc + PW'(1);
            mtime_lo <= mtime_lo_nx;
            mtime_hi <= mtime_hi_nx;
            if (wr_clo)  cmp_lo   <= merge_lanes(cmp_lo, wdata, wr_mask);
            if (wr_chi)  cmp_hi   <= merge_lanes(cmp_hi, wdata, wr_mask);
            if (wr_gpio) gpio_out <= merge_lanes(gpio_out, wdata, wr_mask);
            // Compare uses current registered values: one cycle of lag.
            timer_irq <= ({mtime_hi, mtime_lo} >= {cmp_hi, cmp_lo});
        end
    end

    // RAM array, not reset.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule
